// File: rtl/fsm_staged.sv
// fsm_staged: staged Moore machine that climbs from IDLE through N_STAGES
// intermediate stages into FINAL while 'a' stays high, HOLD cycles per step.
// Optional step-back decay on 'a' low, and an optional FINAL dwell limit that
// forces a LOCKOUT state. All outputs are registered; none see 'a' directly.
module fsm_staged #(
    parameter int N_STAGES      = 1,
    parameter int HOLD          = 1,
    parameter int DECAY_MODE    = 0,
    parameter int FINAL_TIMEOUT = 0,
    parameter int SW            = $clog2(N_STAGES + 3)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          a,
    output logic [SW-1:0] state,
    output logic          out1,
    output logic          out2,
    output logic          enter_final,
    output logic          timeout
);

    localparam int HW = $clog2(HOLD + 1);
    localparam int TW = (FINAL_TIMEOUT > 0) ? $clog2(FINAL_TIMEOUT + 1) : 1;

    localparam logic [SW-1:0] ST_IDLE  = '0;
    localparam logic [SW-1:0] ST_LAST  = SW'(N_STAGES);
    localparam logic [SW-1:0] ST_FINAL = SW'(N_STAGES + 1);
    localparam logic [SW-1:0] ST_LOCK  = SW'(N_STAGES + 2);

    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD - 1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(FINAL_TIMEOUT - 1);
    localparam logic [TW-1:0] TMO_MAX   = TW'(FINAL_TIMEOUT);

    // Coarse classification of the encoded state; stage numbers are
    // parameter-dependent so the register itself stays a plain vector.
    typedef enum logic [2:0] {
        PH_IDLE,
        PH_STAGE,
        PH_FINAL,
        PH_LOCKOUT,
        PH_ILLEGAL
    } phase_t;

    phase_t        phase;
    logic [HW-1:0] hcnt;
    logic [TW-1:0] tmr;
    logic [SW-1:0] next_state;
    logic [HW-1:0] next_hcnt;
    logic [TW-1:0] next_tmr;

    // Decode which kind of state the register currently holds.
    always_comb begin
        if (state == ST_IDLE)
            phase = PH_IDLE;
        else if (state <= ST_LAST)
            phase = PH_STAGE;
        else if (state == ST_FINAL)
            phase = PH_FINAL;
        else if (state == ST_LOCK)
            phase = PH_LOCKOUT;
        else
            phase = PH_ILLEGAL;
    end

    // Next-state rules; hold counter and dwell timer default to cleared so
    // any state change or a-low cycle wipes them.
    always_comb begin
        next_state = state;
        next_hcnt  = '0;
        next_tmr   = '0;
        case (phase)
            PH_IDLE, PH_STAGE: begin
                if (a) begin
                    if (hcnt == HOLD_LAST)
                        next_state = state + SW'(1);
                    else
                        next_hcnt = hcnt + HW'(1);
                end else if (phase == PH_STAGE) begin
                    if (DECAY_MODE != 0)
                        next_state = state - SW'(1);
                    else
                        next_state = ST_IDLE;
                end
            end
            PH_FINAL: begin
                if (a) begin
                    if ((FINAL_TIMEOUT != 0) && (tmr == TMO_LAST))
                        next_state = ST_LOCK;
                    else if (tmr < TMO_MAX)
                        next_tmr = tmr + TW'(1);
                    else
                        next_tmr = tmr;
                end else if (DECAY_MODE != 0) begin
                    next_state = ST_LAST;
                end else begin
                    next_state = ST_IDLE;
                end
            end
            PH_LOCKOUT: begin
                if (!a)
                    next_state = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // State, counters and all outputs register together so outputs follow
    // the state they describe in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            hcnt        <= '0;
            tmr         <= '0;
            out1        <= 1'b0;
            out2        <= 1'b0;
            enter_final <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            state       <= next_state;
            hcnt        <= next_hcnt;
            tmr         <= next_tmr;
            out1        <= (next_state != ST_IDLE) && (next_state <= ST_LAST);
            out2        <= (next_state == ST_FINAL);
            enter_final <= (next_state == ST_FINAL) && (state != ST_FINAL);
            timeout     <= (next_state == ST_LOCK) && (state != ST_LOCK);
        end
    end

endmodule

// File: tb/tb_fsm_staged.sv
// tb_fsm_staged: four differently-parametrised fsm_staged instances share one
// stimulus stream; directed tasks check hand-derived values on the instance
// relevant to each scenario, and a random task checks all instances against
// a behavioural model of the staged-climb rules.
module tb_fsm_staged;

    localparam int PN [4] = '{1, 3, 3, 1};
    localparam int PH [4] = '{1, 2, 1, 1};
    localparam int PD [4] = '{0, 0, 1, 0};
    localparam int PT [4] = '{0, 0, 0, 4};

    logic clk;
    logic rst;
    logic a;

    logic [1:0] s0, s3;
    logic [2:0] s1, s2;
    logic [3:0] o1, o2, ef, to;
    logic [8:0] obs [4];

    int n_cmp;
    int n_bad;

    int m_lvl   [4];
    int m_run   [4];
    int m_dwell [4];
    bit m_lock  [4];
    bit m_ef    [4];
    bit m_to    [4];

    fsm_staged u0 (
        .clk(clk), .rst(rst), .a(a), .state(s0),
        .out1(o1[0]), .out2(o2[0]), .enter_final(ef[0]), .timeout(to[0])
    );
    fsm_staged #(.N_STAGES(3), .HOLD(2)) u1 (
        .clk(clk), .rst(rst), .a(a), .state(s1),
        .out1(o1[1]), .out2(o2[1]), .enter_final(ef[1]), .timeout(to[1])
    );
    fsm_staged #(.N_STAGES(3), .DECAY_MODE(1)) u2 (
        .clk(clk), .rst(rst), .a(a), .state(s2),
        .out1(o1[2]), .out2(o2[2]), .enter_final(ef[2]), .timeout(to[2])
    );
    fsm_staged #(.FINAL_TIMEOUT(4)) u3 (
        .clk(clk), .rst(rst), .a(a), .state(s3),
        .out1(o1[3]), .out2(o2[3]), .enter_final(ef[3]), .timeout(to[3])
    );

    assign obs[0] = {5'(s0), o1[0], o2[0], ef[0], to[0]};
    assign obs[1] = {5'(s1), o1[1], o2[1], ef[1], to[1]};
    assign obs[2] = {5'(s2), o1[2], o2[2], ef[2], to[2]};
    assign obs[3] = {5'(s3), o1[3], o2[3], ef[3], to[3]};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bundle an expected {state, out1, out2, enter_final, timeout}
    function automatic logic [8:0] pk(int st, bit e1, bit e2, bit eef, bit eto);
        return {5'(st), e1, e2, eef, eto};
    endfunction

    function automatic logic [8:0] model_obs(int i);
        int st;
        st = m_lock[i] ? PN[i] + 2 : m_lvl[i];
        return pk(st,
                  !m_lock[i] && m_lvl[i] >= 1 && m_lvl[i] <= PN[i],
                  !m_lock[i] && m_lvl[i] == PN[i] + 1,
                  m_ef[i], m_to[i]);
    endfunction

    // Drive one cycle of inputs, advance the model, sample just after the edge
    task automatic tick(input bit av, input bit rv);
        bit pf, pl;
        a   = av;
        rst = rv;
        @(posedge clk);
        for (int i = 0; i < 4; i++) begin
            if (rv) begin
                m_lvl[i] = 0; m_run[i] = 0; m_dwell[i] = 0;
                m_lock[i] = 0; m_ef[i] = 0; m_to[i] = 0;
            end else begin
                pf = !m_lock[i] && m_lvl[i] == PN[i] + 1;
                pl = m_lock[i];
                if (m_lock[i]) begin
                    if (!av) begin
                        m_lock[i] = 0;
                        m_lvl[i]  = 0;
                    end
                end else if (!av) begin
                    m_run[i]   = 0;
                    m_dwell[i] = 0;
                    if (m_lvl[i] > 0)
                        m_lvl[i] = (PD[i] != 0) ? m_lvl[i] - 1 : 0;
                end else if (m_lvl[i] == PN[i] + 1) begin
                    m_dwell[i]++;
                    if (PT[i] != 0 && m_dwell[i] == PT[i]) begin
                        m_lock[i]  = 1;
                        m_dwell[i] = 0;
                    end
                end else begin
                    m_run[i]++;
                    if (m_run[i] == PH[i]) begin
                        m_lvl[i]++;
                        m_run[i] = 0;
                    end
                end
                m_ef[i] = !m_lock[i] && m_lvl[i] == PN[i] + 1 && !pf;
                m_to[i] = m_lock[i] && !pl;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        tick(0, 1);
        tick(0, 1);
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (obs[i] !== pk(0, 0, 0, 0, 0)) begin
                n_bad++;
                $display("[TB] FAIL reset_u%0d got=%h exp=%h", i, obs[i], pk(0, 0, 0, 0, 0));
            end
        end
        tick(0, 0);
        n_cmp++;
        if (obs[0] !== pk(0, 0, 0, 0, 0)) begin
            n_bad++;
            $display("[TB] FAIL idle_after_reset got=%h exp=%h", obs[0], pk(0, 0, 0, 0, 0));
        end
    endtask

    task automatic test_defaults();
        logic [8:0] exp_v [4];
        exp_v = '{pk(1, 1, 0, 0, 0), pk(2, 0, 1, 1, 0), pk(2, 0, 1, 0, 0), pk(0, 0, 0, 0, 0)};
        tick(0, 1);
        for (int k = 0; k < 4; k++) begin
            tick(k < 3, 0);
            n_cmp++;
            if (obs[0] !== exp_v[k]) begin
                n_bad++;
                $display("[TB] FAIL defaults_step%0d got=%h exp=%h", k, obs[0], exp_v[k]);
            end
        end
    endtask

    task automatic test_hold();
        tick(0, 1);
        for (int k = 1; k <= 8; k++) begin
            tick(1, 0);
            n_cmp++;
            if (s1 !== 3'(k / 2)) begin
                n_bad++;
                $display("[TB] FAIL hold_edge%0d state got=%0d exp=%0d", k, s1, k / 2);
            end
        end
        n_cmp++;
        if ({o2[1], ef[1]} !== 2'b11) begin
            n_bad++;
            $display("[TB] FAIL hold_final out2/ef got=%b exp=11", {o2[1], ef[1]});
        end
        // A single low cycle mid-climb restarts the hold requirement
        tick(0, 1);
        tick(1, 0);
        tick(1, 0);
        tick(0, 0);
        n_cmp++;
        if (s1 !== 3'd0) begin
            n_bad++;
            $display("[TB] FAIL hold_break state got=%0d exp=0", s1);
        end
        tick(1, 0);
        n_cmp++;
        if (s1 !== 3'd0) begin
            n_bad++;
            $display("[TB] FAIL hold_restart1 state got=%0d exp=0", s1);
        end
        tick(1, 0);
        n_cmp++;
        if (s1 !== 3'd1) begin
            n_bad++;
            $display("[TB] FAIL hold_restart2 state got=%0d exp=1", s1);
        end
    endtask

    task automatic test_decay();
        int up [4];
        int dn [5];
        up = '{1, 2, 3, 4};
        dn = '{3, 2, 1, 0, 0};
        tick(0, 1);
        for (int k = 0; k < 4; k++) begin
            tick(1, 0);
            n_cmp++;
            if (obs[2] !== pk(up[k], up[k] <= 3, up[k] == 4, up[k] == 4, 0)) begin
                n_bad++;
                $display("[TB] FAIL decay_up%0d got=%h exp=%h", k, obs[2],
                         pk(up[k], up[k] <= 3, up[k] == 4, up[k] == 4, 0));
            end
        end
        for (int k = 0; k < 5; k++) begin
            tick(0, 0);
            n_cmp++;
            if (obs[2] !== pk(dn[k], dn[k] >= 1, 0, 0, 0)) begin
                n_bad++;
                $display("[TB] FAIL decay_down%0d got=%h exp=%h", k, obs[2],
                         pk(dn[k], dn[k] >= 1, 0, 0, 0));
            end
        end
        // Step back from FINAL to stage 2, then climb again for a second pulse
        for (int k = 0; k < 4; k++) tick(1, 0);
        tick(0, 0);
        tick(0, 0);
        tick(1, 0);
        n_cmp++;
        if (obs[2] !== pk(3, 1, 0, 0, 0)) begin
            n_bad++;
            $display("[TB] FAIL decay_reclimb3 got=%h exp=%h", obs[2], pk(3, 1, 0, 0, 0));
        end
        tick(1, 0);
        n_cmp++;
        if (obs[2] !== pk(4, 0, 1, 1, 0)) begin
            n_bad++;
            $display("[TB] FAIL decay_reenter got=%h exp=%h", obs[2], pk(4, 0, 1, 1, 0));
        end
    endtask

    task automatic test_timeout();
        tick(0, 1);
        tick(1, 0);
        for (int k = 0; k < 4; k++) begin
            tick(1, 0);
            n_cmp++;
            if (obs[3] !== pk(2, 0, 1, k == 0, 0)) begin
                n_bad++;
                $display("[TB] FAIL tmo_dwell%0d got=%h exp=%h", k, obs[3], pk(2, 0, 1, k == 0, 0));
            end
        end
        for (int k = 0; k < 11; k++) begin
            tick(1, 0);
            n_cmp++;
            if (obs[3] !== pk(3, 0, 0, 0, k == 0)) begin
                n_bad++;
                $display("[TB] FAIL tmo_lock%0d got=%h exp=%h", k, obs[3], pk(3, 0, 0, 0, k == 0));
            end
        end
        tick(0, 0);
        n_cmp++;
        if (obs[3] !== pk(0, 0, 0, 0, 0)) begin
            n_bad++;
            $display("[TB] FAIL tmo_exit got=%h exp=%h", obs[3], pk(0, 0, 0, 0, 0));
        end
    endtask

    task automatic test_timeout_race();
        tick(0, 1);
        for (int k = 0; k < 5; k++) tick(1, 0);
        tick(0, 0);
        n_cmp++;
        if (obs[3] !== pk(0, 0, 0, 0, 0)) begin
            n_bad++;
            $display("[TB] FAIL race_low_wins got=%h exp=%h", obs[3], pk(0, 0, 0, 0, 0));
        end
    endtask

    task automatic test_reset_priority();
        tick(0, 1);
        tick(1, 0);
        tick(1, 0);
        tick(1, 0);
        n_cmp++;
        if (obs[0] !== pk(2, 0, 1, 0, 0)) begin
            n_bad++;
            $display("[TB] FAIL rstpri_final got=%h exp=%h", obs[0], pk(2, 0, 1, 0, 0));
        end
        tick(1, 1);
        n_cmp++;
        if (obs[0] !== pk(0, 0, 0, 0, 0)) begin
            n_bad++;
            $display("[TB] FAIL rstpri_reset got=%h exp=%h", obs[0], pk(0, 0, 0, 0, 0));
        end
        tick(1, 0);
        n_cmp++;
        if (obs[0] !== pk(1, 1, 0, 0, 0)) begin
            n_bad++;
            $display("[TB] FAIL rstpri_release got=%h exp=%h", obs[0], pk(1, 1, 0, 0, 0));
        end
    endtask

    task automatic test_random();
        tick(0, 1);
        for (int c = 0; c < 3000; c++) begin
            tick($urandom_range(0, 9) < 8, $urandom_range(0, 149) == 0);
            for (int i = 0; i < 4; i++) begin
                n_cmp++;
                if (obs[i] !== model_obs(i)) begin
                    n_bad++;
                    $display("[TB] FAIL random_u%0d cycle %0d got=%h exp=%h", i, c, obs[i], model_obs(i));
                end
            end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        a     = 1'b0;
        rst   = 1'b1;
        test_reset();
        test_defaults();
        test_hold();
        test_decay();
        test_timeout();
        test_timeout_race();
        test_reset_priority();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
